// File: rtl/iob_wb_pkg.sv
// Shared Wishbone codes and FSM encoding for the memory responder.
package iob_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Codes 011..110 are reserved and answered with an error beat.
  function automatic logic cti_reserved(input logic [2:0] cti);
    return (cti >= 3'b011) && (cti <= 3'b110);
  endfunction

endpackage

// File: rtl/iob_wb_burst_addr.sv
// Next beat address for Wishbone bursts: linear +4 or wrap-4/8/16 on word bits.
module iob_wb_burst_addr
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [1:0]        bte_i,
  output logic [ADDR_W-1:0] nxt_adr_o
);

  logic [ADDR_W-1:0] inc;
  assign inc = adr_i + ADDR_W'(4);

  // Wrapping modes take only the low word bits from the incremented value.
  always_comb begin
    nxt_adr_o = adr_i;
    case (bte_i)
      BTE_LINEAR: nxt_adr_o      = inc;
      BTE_WRAP4:  nxt_adr_o[3:2] = inc[3:2];
      BTE_WRAP8:  nxt_adr_o[4:2] = inc[4:2];
      default:    nxt_adr_o[5:2] = inc[5:2];
    endcase
  end

endmodule

// File: rtl/iob_wb_mem_responder.sv
// Wishbone B4 memory responder with programmable wait states and burst support.
module iob_wb_mem_responder
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_W  = 10
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  input  logic [3:0]        wait_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int DEPTH = 1 << MEM_W;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic              err_q;
  logic [DATA_W-1:0] dat_q;

  logic              req;
  logic              load;
  logic [ADDR_W-1:0] beat_adr;
  logic              beat_err;
  logic [ADDR_W-1:0] nxt_adr;
  logic              wr_en;
  logic [MEM_W-1:0]  rd_idx, wr_idx;

  logic [3:0][7:0]   mem [DEPTH];

  assign req = wb_cyc_i & wb_stb_i;

  iob_wb_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
    .adr_i     (adr_q),
    .bte_i     (wb_bte_i),
    .nxt_adr_o (nxt_adr)
  );

  // load marks entry into ACK for a new beat; beat_adr is that beat's address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    load     = 1'b0;
    beat_adr = wb_adr_i;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d = wb_we_i;
          if (wait_i == 4'd0) begin
            state_d = ST_ACK;
            load    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_i;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_ACK;
            load    = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (req && wb_cti_i == CTI_INCR) begin
          load     = 1'b1;
          beat_adr = nxt_adr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) adr_d = beat_adr;
  end

  assign beat_err = (|(beat_adr >> (MEM_W + 2))) | cti_reserved(wb_cti_i);
  assign rd_idx   = beat_adr[MEM_W+1:2];
  assign wr_idx   = adr_q[MEM_W+1:2];

  // Reset forces state_q out of ACK asynchronously, which kills any pending write.
  assign wr_en = (state_q == ST_ACK) & req & we_q & ~err_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      if (load) begin
        err_q <= beat_err;
        dat_q <= (beat_err || we_d) ? '0 : mem[rd_idx];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[wr_idx][b] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = (state_q == ST_ACK) & ~err_q;
  assign wb_err_o = (state_q == ST_ACK) & err_q;

endmodule

// File: tb/tb_iob_wb_mem_responder.sv
// Scoreboard bench: stimulus pushes expected beats, a forked monitor pops on ack/err.
module tb_iob_wb_mem_responder;
  import iob_wb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_W  = 10;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic [ADDR_W-1:0] adr = '0;
  logic [3:0]        sel = '0;
  logic              we = 1'b0;
  logic              cyc = 1'b0;
  logic              stb = 1'b0;
  logic [DATA_W-1:0] dati = '0;
  logic [2:0]        cti = '0;
  logic [1:0]        bte = '0;
  logic [3:0]        wt = '0;
  logic [DATA_W-1:0] dato;
  logic              ack, err;

  always #5 clk = ~clk;

  iob_wb_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W)) dut (
    .clk_i(clk), .arst_i(arst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_i(dati), .wb_cti_i(cti), .wb_bte_i(bte),
    .wait_i(wt), .wb_dat_o(dato), .wb_ack_o(ack), .wb_err_o(err)
  );

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] bd[8];
  logic [31:0] be[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic e, input logic c, input logic [31:0] d);
    exp_t x;
    x.err = e; x.chk = c; x.dat = d; x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (ack || err) begin
        if (sbq.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else begin
          exp_t e = sbq.pop_front();
          check({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
          check({e.name, "_ack"}, {31'd0, ack}, {31'd0, !e.err});
          if (e.chk) check({e.name, "_dat"}, dato, e.dat);
        end
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
    adr = a; we = w; sel = s; dati = d; cti = c; bte = b; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; sel = '0;
  endtask

  task automatic wait_beat(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack || err) && n < 40);
    if (!(ack || err)) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic gap_check(input string nm);
    @(negedge clk);
    check({nm, "_gap"}, {30'd0, ack, err}, 32'd0);
  endtask

  task automatic single(input string nm, input logic [31:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d, input logic [2:0] c,
                        input logic [3:0] ws, input logic e_err, input logic [31:0] e_dat);
    int n;
    @(posedge clk); #1;
    wt = ws;
    push(nm, e_err, !w, e_dat);
    drive(a, w, s, d, c, BTE_LINEAR);
    wait_beat(nm, n);
    check({nm, "_lat"}, n, 32'(ws) + 32'd2);
    @(posedge clk); #1;
    idle_bus();
    gap_check(nm);
  endtask

  // Beats use bd[] as write data and be[] as expected read data.
  task automatic burst(input string nm, input logic [31:0] a, input logic w,
                       input logic [1:0] b, input int beats, input logic [3:0] ws);
    int n;
    @(posedge clk); #1;
    wt = ws;
    push({nm, "_b0"}, 1'b0, !w, be[0]);
    drive(a, w, 4'hf, bd[0], CTI_INCR, b);
    wait_beat(nm, n);
    check({nm, "_lat"}, n, 32'(ws) + 32'd2);
    for (int i = 1; i < beats; i++) begin
      @(posedge clk); #1;
      dati = bd[i];
      cti  = (i == beats - 1) ? CTI_EOB : CTI_INCR;
      push($sformatf("%s_b%0d", nm, i), 1'b0, !w, be[i]);
      @(negedge clk);
      if (!(ack || err)) check($sformatf("%s_consec%0d", nm, i), 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    idle_bus();
    gap_check(nm);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none
    idle_bus();
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dat", dato, 32'd0);
    @(posedge clk); #1;
    arst = 1'b1;

    single("wr_full", 32'h10, 1'b1, 4'hf, 32'hDEADBEEF, CTI_CLASSIC, 4'd0, 1'b0, 32'h0);
    single("rd_full", 32'h10, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, 4'd0, 1'b0, 32'hDEADBEEF);
    single("wr_byte", 32'h10, 1'b1, 4'b0010, 32'h0000AB00, CTI_CLASSIC, 4'd3, 1'b0, 32'h0);
    single("rd_byte", 32'h10, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, 4'd1, 1'b0, 32'hDEADABEF);

    for (int i = 0; i < 4; i++)
      single($sformatf("pre%0d", i), 32'(4 * i), 1'b1, 4'hf, 32'hA0000000 + 32'(i),
             CTI_CLASSIC, 4'd0, 1'b0, 32'h0);

    be[0] = 32'hA0000002; be[1] = 32'hA0000003; be[2] = 32'hA0000000; be[3] = 32'hA0000001;
    burst("wrap4_rd", 32'h08, 1'b0, BTE_WRAP4, 4, 4'd2);

    single("oob_wr", 32'h1000, 1'b1, 4'hf, 32'hFFFFFFFF, CTI_CLASSIC, 4'd0, 1'b1, 32'h0);
    single("oob_chk", 32'h00, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, 4'd0, 1'b0, 32'hA0000000);
    single("cti_rsv", 32'h10, 1'b0, 4'h0, 32'h0, 3'b011, 4'd0, 1'b1, 32'h0);

    bd[0] = 32'hC0000000; bd[1] = 32'hC0000001; bd[2] = 32'hC0000002;
    burst("incr_wr", 32'h20, 1'b1, BTE_LINEAR, 3, 4'd0);
    be[0] = 32'hC0000000; be[1] = 32'hC0000001; be[2] = 32'hC0000002;
    burst("incr_rd", 32'h20, 1'b0, BTE_LINEAR, 3, 4'd1);

    // Reset during beat 2 of an 8-beat incrementing write.
    single("pre40", 32'h40, 1'b1, 4'hf, 32'h0, CTI_CLASSIC, 4'd0, 1'b0, 32'h0);
    single("pre44", 32'h44, 1'b1, 4'hf, 32'h12345678, CTI_CLASSIC, 4'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    wt = 4'd0;
    push("rst_b0", 1'b0, 1'b0, 32'h0);
    drive(32'h40, 1'b1, 4'hf, 32'hB0000001, CTI_INCR, BTE_LINEAR);
    wait_beat("rst_b0", n);
    @(posedge clk); #1;
    dati = 32'hB0000002;
    push("rst_b1", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    if (!(ack || err)) check("rst_b1_present", 32'd0, 32'd1);
    #1;
    arst = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_dat", dato, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    arst = 1'b1;
    single("post_rd40", 32'h40, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, 4'd0, 1'b0, 32'hB0000001);
    single("post_rd44", 32'h44, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, 4'd0, 1'b0, 32'h12345678);

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
